// File: rtl/mipi_tx_raw10_packer.sv
// RAW10 transmit packer: 4x10-bit pixel groups in, CSI-2 RAW10 bytes out as 32-bit words.
// A 9-byte shift buffer absorbs the 5-in/4-out rate mismatch; the last word of a line may be partial.
module mipi_tx_raw10_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        pixel_valid_i,
    input  logic [39:0] pixel_i,
    input  logic        pixel_last_i,
    output logic        pixel_ready_o,
    output logic        output_valid_o,
    output logic [31:0] output_o,
    output logic [2:0]  output_bytes_o,
    output logic        output_last_o,
    input  logic        output_ready_i
);

    logic [7:0] sbuf_q [9];
    logic [7:0] sbuf_d [9];
    logic [7:0] grp    [5];
    logic [3:0] byte_cnt, byte_cnt_d;
    logic [3:0] rem, base;
    logic       last_pending;
    logic       in_fire, out_fire;

    always_comb begin
        pixel_ready_o  = !last_pending && (byte_cnt <= 4'd4);
        output_valid_o = (byte_cnt >= 4'd4) || (last_pending && (byte_cnt != 4'd0));
        output_bytes_o = (byte_cnt >= 4'd4) ? 3'd4 : byte_cnt[2:0];
        output_last_o  = last_pending && (byte_cnt <= 4'd4);
        for (int i = 0; i < 4; i++)
            output_o[8*i +: 8] = (4'(i) < byte_cnt) ? sbuf_q[i] : PAD_BYTE;
    end

    assign in_fire  = pixel_valid_i && pixel_ready_o;
    assign out_fire = output_valid_o && output_ready_i;

    // Five MSB bytes first, then the packed LSB byte with pixel0's LSBs on top.
    always_comb begin
        grp[0] = pixel_i[39:32];
        grp[1] = pixel_i[29:22];
        grp[2] = pixel_i[19:12];
        grp[3] = pixel_i[9:2];
        grp[4] = {pixel_i[31:30], pixel_i[21:20], pixel_i[11:10], pixel_i[1:0]};
    end

    // Drain first, then append at the new tail, so a simultaneous in/out never exceeds 9 bytes.
    always_comb begin
        rem  = out_fire ? {1'b0, output_bytes_o} : 4'd0;
        base = byte_cnt - rem;
        for (int i = 0; i < 9; i++) begin
            sbuf_d[i] = PAD_BYTE;
            if (i + int'(rem) < 9)
                sbuf_d[i] = sbuf_q[i + int'(rem)];
        end
        if (in_fire) begin
            for (int j = 0; j < 5; j++)
                if (int'(base) + j < 9)
                    sbuf_d[int'(base) + j] = grp[j];
        end
        byte_cnt_d = base + (in_fire ? 4'd5 : 4'd0);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            byte_cnt     <= 4'd0;
            last_pending <= 1'b0;
            for (int i = 0; i < 9; i++)
                sbuf_q[i] <= PAD_BYTE;
        end else begin
            byte_cnt <= byte_cnt_d;
            for (int i = 0; i < 9; i++)
                sbuf_q[i] <= sbuf_d[i];
            if (out_fire && output_last_o)
                last_pending <= 1'b0;
            if (in_fire && pixel_last_i)
                last_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mipi_tx_raw10_packer.sv
// Randomized bench for mipi_tx_raw10_packer against a byte-queue reference model and a software depacker.
module tb_mipi_tx_raw10_packer;

    localparam logic [7:0] PAD = 8'h00;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        pixel_valid_i;
    logic [39:0] pixel_i;
    logic        pixel_last_i;
    logic        pixel_ready_o;
    logic        output_valid_o;
    logic [31:0] output_o;
    logic [2:0]  output_bytes_o;
    logic        output_last_o;
    logic        output_ready_i;

    mipi_tx_raw10_packer #(.PAD_BYTE(PAD)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .pixel_valid_i(pixel_valid_i), .pixel_i(pixel_i), .pixel_last_i(pixel_last_i),
        .pixel_ready_o(pixel_ready_o),
        .output_valid_o(output_valid_o), .output_o(output_o),
        .output_bytes_o(output_bytes_o), .output_last_o(output_last_o),
        .output_ready_i(output_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] d;
        int          nb;
        bit          l;
    } wd_t;

    wd_t         exp_q[$];
    wd_t         got_q[$];
    logic [7:0]  pend[$];
    logic [39:0] sent_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          ord_mode = 0;   // 0 ready high, 1 random, 3 driven by main block

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: every group is 5 bytes in stream order; words are cut 4 bytes at a time,
    // with the line's tail (1..4 bytes) flagged last.
    task automatic model_push(input logic [39:0] g, input bit last);
        logic [9:0] p [4];
        wd_t w;
        for (int k = 0; k < 4; k++) p[k] = g[39-10*k -: 10];
        for (int k = 0; k < 4; k++) pend.push_back(p[k][9:2]);
        pend.push_back({p[0][1:0], p[1][1:0], p[2][1:0], p[3][1:0]});
        while (pend.size() > 4) begin
            w.d = 0;
            for (int k = 0; k < 4; k++) w.d[8*k +: 8] = pend.pop_front();
            w.nb = 4; w.l = 0;
            exp_q.push_back(w);
        end
        if (last) begin
            w.nb = pend.size();
            w.l  = 1;
            for (int k = 0; k < 4; k++) w.d[8*k +: 8] = (k < w.nb) ? pend.pop_front() : PAD;
            exp_q.push_back(w);
        end
    endtask

    task automatic send_group(input logic [39:0] g, input bit last);
        int to = 0;
        @(negedge clk_i);
        pixel_valid_i = 1'b1; pixel_i = g; pixel_last_i = last;
        #1;
        while (!pixel_ready_o && to < 1000) begin
            @(negedge clk_i); #1; to++;
        end
        if (to >= 1000) chk("accept_timeout", 64'(to), 64'(0));
        @(posedge clk_i);
        model_push(g, last);
        sent_q.push_back(g);
        #1;
        pixel_valid_i = 1'b0; pixel_last_i = 1'b0;
        if ($urandom_range(0, 3) == 0) @(negedge clk_i);
    endtask

    task automatic drain_compare(input string tag);
        int to = 0;
        while (got_q.size() < exp_q.size() && to < 2000) begin
            @(negedge clk_i); to++;
        end
        repeat (3) @(negedge clk_i);
        chk({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            chk({tag, "_data"},  64'(got_q[k].d),  64'(exp_q[k].d));
            chk({tag, "_bytes"}, 64'(got_q[k].nb), 64'(exp_q[k].nb));
            chk({tag, "_last"},  64'(got_q[k].l),  64'(exp_q[k].l));
        end
    endtask

    task automatic clear_model();
        exp_q.delete(); got_q.delete(); pend.delete(); sent_q.delete();
    endtask

    // Output-side monitor: drives output_ready_i, records fired words, checks hold and ready rules.
    initial begin
        bit          prev_stall = 0, prev_lastfire = 0, prev_rst = 1;
        logic [31:0] held_d = 0;
        logic [2:0]  held_b = 0;
        wd_t         w;
        output_ready_i = 1'b1;
        forever begin
            @(negedge clk_i);
            if (ord_mode == 0)      output_ready_i = 1'b1;
            else if (ord_mode == 1) output_ready_i = ($urandom_range(0, 2) != 0);
            #2;
            if (prev_stall && !prev_rst) begin
                chk("hold_valid", 64'(output_valid_o), 64'(1));
                chk("hold_data",  64'(output_o),       64'(held_d));
                chk("hold_bytes", 64'(output_bytes_o), 64'(held_b));
            end
            if (prev_lastfire && !prev_rst)
                chk("ready_after_last", 64'(pixel_ready_o), 64'(1));
            if (output_valid_o && output_last_o)
                chk("ready_low_last", 64'(pixel_ready_o), 64'(0));
            if (output_valid_o && output_ready_i && !reset_i) begin
                w.d = output_o; w.nb = int'(output_bytes_o); w.l = output_last_o;
                got_q.push_back(w);
                chk("cnt_bound", 64'(dut.byte_cnt <= 4'd9), 64'(1));
            end
            prev_stall    = output_valid_o && !output_ready_i && !reset_i;
            prev_lastfire = output_valid_o && output_ready_i && output_last_o && !reset_i;
            held_d        = output_o;
            held_b        = output_bytes_o;
            prev_rst      = reset_i;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(output_valid_o), 64'(0));
        chk({tag, "_last"},  64'(output_last_o),  64'(0));
        chk({tag, "_bytes"}, 64'(output_bytes_o), 64'(0));
        chk({tag, "_data"},  64'(output_o),       64'({4{PAD}}));
        chk({tag, "_ready"}, 64'(pixel_ready_o),  64'(1));
    endtask

    initial begin
        logic [7:0]  bytes[$];
        logic [39:0] g;
        reset_i = 1'b1; pixel_valid_i = 1'b0; pixel_i = '0; pixel_last_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1 check_reset_outputs("rst0");
        reset_i = 1'b0;

        // Directed single group with last
        send_group({10'h3FF, 10'h000, 10'h155, 10'h2AA}, 1);
        drain_compare("single");
        if (got_q.size() == 2) begin
            chk("single_w0", 64'(got_q[0].d), 64'h00000000AA5500FF);
            chk("single_w1", 64'(got_q[1].d), 64'h00000000000000C6);
            chk("single_b1", 64'(got_q[1].nb), 64'(1));
        end
        clear_model();

        // Four groups: 20 bytes, exactly five full words
        for (int i = 0; i < 4; i++) send_group(40'({$urandom, $urandom}), i == 3);
        drain_compare("four");
        chk("four_nwords", 64'(got_q.size()), 64'(5));
        clear_model();

        // Three groups: 15 bytes, last word has 3 bytes and padded top lane
        for (int i = 0; i < 3; i++) send_group(40'({$urandom, $urandom}), i == 2);
        drain_compare("three");
        chk("three_nwords", 64'(got_q.size()), 64'(4));
        if (got_q.size() == 4) begin
            chk("three_tail_bytes", 64'(got_q[3].nb), 64'(3));
            chk("three_tail_pad",   64'(got_q[3].d[31:24]), 64'(PAD));
        end
        clear_model();

        // 100 random groups with random backpressure and random line lengths
        ord_mode = 1;
        for (int i = 0; i < 100; i++)
            send_group(40'({$urandom, $urandom}), (i == 99) || ($urandom_range(0, 6) == 0));
        drain_compare("rand");
        clear_model();

        // Mid-line reset with byte_cnt = 7 and last pending
        ord_mode = 3;
        @(negedge clk_i);
        output_ready_i = 0; pixel_valid_i = 1; pixel_i = 40'h12345_6789A; pixel_last_i = 0;
        @(negedge clk_i); output_ready_i = 1; pixel_valid_i = 0;
        @(negedge clk_i); output_ready_i = 0; pixel_valid_i = 1; pixel_i = 40'hFEDCB_A9876;
        @(negedge clk_i); output_ready_i = 1; pixel_valid_i = 0;
        @(negedge clk_i); output_ready_i = 0; pixel_valid_i = 1; pixel_i = 40'h0F0F0_F0F0F; pixel_last_i = 1;
        @(negedge clk_i); pixel_valid_i = 0; pixel_last_i = 0;
        #1 chk("pre_rst_cnt", 64'(dut.byte_cnt), 64'(7));
        chk("pre_rst_lastpend", 64'(dut.last_pending), 64'(1));
        reset_i = 1;
        @(negedge clk_i); reset_i = 0;
        #1 check_reset_outputs("midrst");
        clear_model();
        ord_mode = 0;
        send_group({10'h3FF, 10'h000, 10'h155, 10'h2AA}, 1);
        drain_compare("post_rst");
        clear_model();

        // Loopback: three 20-group lines, depacked in software and compared to what was sent
        ord_mode = 1;
        for (int ln = 0; ln < 3; ln++)
            for (int i = 0; i < 20; i++) send_group(40'({$urandom, $urandom}), i == 19);
        drain_compare("loop");
        foreach (got_q[k])
            for (int b = 0; b < got_q[k].nb; b++) bytes.push_back(got_q[k].d[8*b +: 8]);
        chk("loop_nbytes", 64'(bytes.size()), 64'(5 * sent_q.size()));
        for (int i = 0; i < sent_q.size() && 5*i + 4 < bytes.size(); i++) begin
            for (int k = 0; k < 4; k++)
                g[39-10*k -: 10] = {bytes[5*i+k], bytes[5*i+4][7-2*k -: 2]};
            chk("loop_pixels", 64'(g), 64'(sent_q[i]));
        end
        clear_model();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
